reg_bus_sequencer: RTL and testbench

- Sequences single register-to-register or immediate-to-register transfers over the shared tri-state data bus of the CPU register bank.
- Drives the per-register chip-select lines (cs: 1 = output high-Z, 0 = drive bus) and the per-register load enables that feed each register's ClockEnable.
- Sits directly upstream of the register flip-flops, between the control unit and the register bank.
- All activity is paced by the global Tick strobe, so transfers stay in step with the registers' ClockEnable&Tick capture rule.

---
 rtl/reg_bus_sequencer.sv | 125 ++++++++++++
 tb/tb_reg_bus_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_sequencer.sv
// Purpose: sequences one register->register or immediate->register move over the shared tri-state register bus.
// Latency: 3 Tick edges from request acceptance to done; requests are at least 4 Tick edges apart.
// Backpressure: req is only sampled in IDLE; while busy or done, all request inputs are ignored.
//
// Ports:
//   Clock, Reset (async, active-high), Tick (advance strobe)
//   req/src_sel/dst_sel/imm_en/imm_data : transfer request, latched on acceptance
//   bus_in     : resolved value of the shared bus, captured into last_value at the end of LATCH
//   cs         : per-register chip-select (1 = high-Z, 0 = drive bus)
//   load_en    : one-hot destination enable feeding each register's ClockEnable
//   bus_drive  : enable for the immediate tri-state driver; bus_out is its data
//   busy, done, last_value : status
module reg_bus_sequencer #(
    parameter int NrOfBits    = 8,
    parameter int RegAddrBits = 2,
    localparam int NrOfRegs   = 2**RegAddrBits
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   Tick,
    input  logic                   req,
    input  logic [RegAddrBits-1:0] src_sel,
    input  logic [RegAddrBits-1:0] dst_sel,
    input  logic                   imm_en,
    input  logic [NrOfBits-1:0]    imm_data,
    input  logic [NrOfBits-1:0]    bus_in,
    output logic [NrOfRegs-1:0]    cs,
    output logic [NrOfRegs-1:0]    load_en,
    output logic                   bus_drive,
    output logic [NrOfBits-1:0]    bus_out,
    output logic                   busy,
    output logic                   done,
    output logic [NrOfBits-1:0]    last_value
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_LATCH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Transfer fields, frozen for the whole transfer so bus drive never shifts mid-move.
    logic [RegAddrBits-1:0] src_q;
    logic [RegAddrBits-1:0] dst_q;
    logic                   imm_en_q;
    logic [NrOfBits-1:0]    imm_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else if (Tick) begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            src_q    <= '0;
            dst_q    <= '0;
            imm_en_q <= 1'b0;
            imm_q    <= '0;
        end else if (Tick && (state == ST_IDLE) && req) begin
            src_q    <= src_sel;
            dst_q    <= dst_sel;
            imm_en_q <= imm_en;
            imm_q    <= imm_data;
        end
    end

    // The destination register captures the bus on this same Tick edge; mirror it here.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            last_value <= '0;
        end else if (Tick && (state == ST_LATCH)) begin
            last_value <= bus_in;
        end
    end

    // Outputs decode only registered state and latched fields, so they are glitch-free.
    always_comb begin
        state_nxt = state;
        cs        = '1;
        load_en   = '0;
        bus_drive = 1'b0;
        bus_out   = '0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (req) begin
                    state_nxt = ST_DRIVE;
                end
            end
            ST_DRIVE, ST_LATCH: begin
                busy = 1'b1;
                // Exactly one bus source: either the immediate driver or one register.
                if (imm_en_q) begin
                    bus_drive = 1'b1;
                    bus_out   = imm_q;
                end else begin
                    cs[src_q] = 1'b0;
                end
                if (state == ST_LATCH) begin
                    load_en[dst_q] = 1'b1;
                    state_nxt      = ST_DONE;
                end else begin
                    state_nxt      = ST_LATCH;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_bus_sequencer.sv
// Purpose: self-checking bench for reg_bus_sequencer with a small register bank and bus model around it.
// Latency: checks the 3-Tick request-to-done latency and the 4-Tick request spacing.
// Backpressure: checks that requests issued while busy are ignored until the block is back in IDLE.
module tb_reg_bus_sequencer;

    localparam int NB = 8;
    localparam int AB = 2;
    localparam int NR = 4;
    localparam int VW = 2*NR + 3 + NB;

    logic          Clock;
    logic          Reset;
    logic          Tick;
    logic          req;
    logic [AB-1:0] src_sel;
    logic [AB-1:0] dst_sel;
    logic          imm_en;
    logic [NB-1:0] imm_data;
    logic [NB-1:0] bus_in;
    logic [NR-1:0] cs;
    logic [NR-1:0] load_en;
    logic          bus_drive;
    logic [NB-1:0] bus_out;
    logic          busy;
    logic          done;
    logic [NB-1:0] last_value;

    int n_tests;
    int n_fail;

    reg_bus_sequencer #(.NrOfBits(NB), .RegAddrBits(AB)) dut (
        .Clock(Clock), .Reset(Reset), .Tick(Tick), .req(req),
        .src_sel(src_sel), .dst_sel(dst_sel), .imm_en(imm_en), .imm_data(imm_data),
        .bus_in(bus_in), .cs(cs), .load_en(load_en), .bus_drive(bus_drive),
        .bus_out(bus_out), .busy(busy), .done(done), .last_value(last_value)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    function automatic logic [NB-1:0] init_val(int i);
        return 8'h11 * 8'(i + 1);
    endfunction

    // Register bank environment: captures the bus on load_en & Tick, like the real flip-flops.
    logic [NB-1:0] bank [NR];
    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NR; i++) bank[i] <= init_val(i);
        end else if (Tick) begin
            for (int i = 0; i < NR; i++) if (load_en[i]) bank[i] <= bus_in;
        end
    end

    // Bus resolution: contention between two drivers shows up as X.
    always_comb begin
        bus_in = '0;
        if (bus_drive) bus_in = bus_out;
        for (int i = 0; i < NR; i++) begin
            if (!cs[i]) bus_in = bus_drive ? 'x : bank[i];
        end
    end

    // Reference model: a transfer is a count of Tick edges since acceptance (-1 = no transfer).
    // 1 and 2 are the bus-drive Ticks (2 also loads), 3 is the done Tick.
    int            mk;
    logic [AB-1:0] m_src;
    logic [AB-1:0] m_dst;
    logic          m_imm_en;
    logic [NB-1:0] m_imm;
    logic [NB-1:0] m_last;
    logic [NB-1:0] mregs [NR];

    task automatic model_reset();
        mk = -1; m_src = '0; m_dst = '0; m_imm_en = 1'b0; m_imm = '0; m_last = '0;
        for (int i = 0; i < NR; i++) mregs[i] = init_val(i);
    endtask

    function automatic logic [NR-1:0] exp_cs();
        if ((mk == 1 || mk == 2) && !m_imm_en) return ~(NR'(1) << m_src);
        return '1;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [NR-1:0] ld;
        logic          drv;
        ld  = (mk == 2) ? (NR'(1) << m_dst) : '0;
        drv = (mk == 1 || mk == 2) && m_imm_en;
        return {exp_cs(), ld, drv, (mk == 1 || mk == 2), (mk == 3), m_last};
    endfunction

    logic [VW-1:0] obs_vec;
    assign obs_vec = {cs, load_en, bus_drive, busy, done, last_value};

    // One clock: inputs are sampled as they stand, the model advances, outputs are read 1 time unit later.
    task automatic step();
        logic          t_tick, t_req, t_imm_en;
        logic [AB-1:0] t_src, t_dst;
        logic [NB-1:0] t_imm;
        t_tick = Tick; t_req = req; t_imm_en = imm_en; t_src = src_sel; t_dst = dst_sel; t_imm = imm_data;
        @(posedge Clock);
        if (t_tick) begin
            if (mk < 0) begin
                if (t_req) begin
                    m_src = t_src; m_dst = t_dst; m_imm_en = t_imm_en; m_imm = t_imm; mk = 1;
                end
            end else if (mk == 2) begin
                m_last = m_imm_en ? m_imm : mregs[m_src];
                mregs[m_dst] = m_last;
                mk = 3;
            end else if (mk == 3) begin
                mk = -1;
            end else begin
                mk = mk + 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Tick = 1'b0; req = 1'b0; imm_en = 1'b0;
        src_sel = '0; dst_sel = '0; imm_data = '0;
        model_reset();
        repeat (2) @(posedge Clock);
        #1;
        n_tests++; if (cs !== 4'hF) begin n_fail++; $display("FAIL reset_cs got %b expected 1111", cs); end
        n_tests++; if (load_en !== 4'h0) begin n_fail++; $display("FAIL reset_load_en got %b expected 0000", load_en); end
        n_tests++; if (bus_drive !== 1'b0) begin n_fail++; $display("FAIL reset_bus_drive got %b expected 0", bus_drive); end
        n_tests++; if (bus_out !== 8'h00) begin n_fail++; $display("FAIL reset_bus_out got %h expected 00", bus_out); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b expected 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b expected 0", done); end
        n_tests++; if (last_value !== 8'h00) begin n_fail++; $display("FAIL reset_last_value got %h expected 00", last_value); end
        // Release with req and Tick already high: accepted on the first edge.
        req = 1'b1; Tick = 1'b1; imm_en = 1'b1; imm_data = 8'h3C; dst_sel = 2'd1;
        Reset = 1'b0;
        step();
        req = 1'b0;
        n_tests++; if (busy !== 1'b1 || bus_out !== 8'h3C) begin
            n_fail++; $display("FAIL release_accept got busy=%b bus_out=%h expected busy=1 bus_out=3c", busy, bus_out);
        end
        repeat (3) step();
        n_tests++; if (last_value !== 8'h3C || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL release_complete got last=%h busy=%b done=%b expected last=3c busy=0 done=0", last_value, busy, done);
        end
    endtask

    task automatic test_imm();
        req = 1'b1; imm_en = 1'b1; imm_data = 8'hA5; dst_sel = 2'd2; src_sel = 2'd0; Tick = 1'b1;
        step();
        req = 1'b0;
        n_tests++; if (cs !== 4'hF) begin n_fail++; $display("FAIL imm_drive_cs got %b expected 1111", cs); end
        n_tests++; if (bus_drive !== 1'b1) begin n_fail++; $display("FAIL imm_drive_en got %b expected 1", bus_drive); end
        n_tests++; if (bus_out !== 8'hA5) begin n_fail++; $display("FAIL imm_drive_bus_out got %h expected a5", bus_out); end
        n_tests++; if (load_en !== 4'h0) begin n_fail++; $display("FAIL imm_drive_load_en got %b expected 0000", load_en); end
        step();
        n_tests++; if (load_en !== 4'b0100) begin n_fail++; $display("FAIL imm_latch_load_en got %b expected 0100", load_en); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL imm_latch_done got %b expected 0", done); end
        step();
        n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL imm_done got %b expected 1", done); end
        n_tests++; if (last_value !== 8'hA5) begin n_fail++; $display("FAIL imm_last_value got %h expected a5", last_value); end
        step();
    endtask

    task automatic test_reg_move();
        req = 1'b1; imm_en = 1'b0; src_sel = 2'd2; dst_sel = 2'd0; imm_data = 8'h00; Tick = 1'b1;
        step();
        req = 1'b0;
        n_tests++; if (cs !== 4'b1011 || bus_drive !== 1'b0 || load_en !== 4'h0) begin
            n_fail++; $display("FAIL move_drive got cs=%b drv=%b ld=%b expected cs=1011 drv=0 ld=0000", cs, bus_drive, load_en);
        end
        step();
        n_tests++; if (cs !== 4'b1011 || load_en !== 4'b0001) begin
            n_fail++; $display("FAIL move_latch got cs=%b ld=%b expected cs=1011 ld=0001", cs, load_en);
        end
        step();
        n_tests++; if (done !== 1'b1 || last_value !== 8'hA5 || cs !== 4'hF) begin
            n_fail++; $display("FAIL move_done got done=%b last=%h cs=%b expected done=1 last=a5 cs=1111", done, last_value, cs);
        end
        step();
        n_tests++; if (bank[0] !== 8'hA5) begin n_fail++; $display("FAIL move_bank0 got %h expected a5", bank[0]); end
    endtask

    task automatic test_slow_tick();
        int rise;
        int hi;
        rise = -1; hi = 0;
        req = 1'b1; imm_en = 1'b0; src_sel = 2'd1; dst_sel = 2'd3;
        // req goes high right after a Tick; Ticks then land on every 4th clock.
        for (int c = 0; c < 24; c++) begin
            Tick = ((c % 4) == 3);
            step();
            if (c == 3) req = 1'b0;
            if (done && rise < 0) rise = c + 1;
            if (done) hi++;
            n_tests++; if (obs_vec !== exp_vec()) begin
                n_fail++; $display("FAIL slow_cycle%0d got %h expected %h", c, obs_vec, exp_vec());
            end
        end
        n_tests++; if (rise !== 12) begin n_fail++; $display("FAIL slow_done_rise got %0d expected 12", rise); end
        n_tests++; if (hi !== 4) begin n_fail++; $display("FAIL slow_done_width got %0d expected 4", hi); end
    endtask

    task automatic test_ignore_busy();
        req = 1'b1; imm_en = 1'b1; imm_data = 8'h5A; dst_sel = 2'd3; src_sel = 2'd0; Tick = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            n_tests++; if (obs_vec !== exp_vec()) begin
                n_fail++; $display("FAIL busy_cycle%0d got %h expected %h", c, obs_vec, exp_vec());
            end
            if (c == 0) begin
                n_tests++; if (bus_out !== 8'h5A) begin n_fail++; $display("FAIL busy_first_bus_out got %h expected 5a", bus_out); end
            end
            if (c == 3) begin
                n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin
                    n_fail++; $display("FAIL busy_gap got busy=%b done=%b expected 0 0", busy, done);
                end
            end
            if (c == 4) begin
                n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_second_start got %b expected 1", busy); end
            end
            src_sel = AB'($urandom); dst_sel = AB'($urandom); imm_data = NB'($urandom); imm_en = 1'($urandom);
            if (c == 5) req = 1'b0;
        end
        for (int k = 0; k < 8 && mk >= 0; k++) step();
        n_tests++; if (busy !== 1'b0 || mk >= 0) begin n_fail++; $display("FAIL busy_drain got busy=%b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        req = 1'b1; imm_en = 1'b0; src_sel = 2'd3; dst_sel = 2'd1; Tick = 1'b1;
        step();
        req = 1'b0;
        step();
        n_tests++; if (load_en !== 4'b0010) begin n_fail++; $display("FAIL mid_latch_load_en got %b expected 0010", load_en); end
        #1 Reset = 1'b1;
        #1;
        n_tests++; if (cs !== 4'hF) begin n_fail++; $display("FAIL mid_reset_cs got %b expected 1111", cs); end
        n_tests++; if (load_en !== 4'h0) begin n_fail++; $display("FAIL mid_reset_load_en got %b expected 0000", load_en); end
        n_tests++; if (bus_drive !== 1'b0) begin n_fail++; $display("FAIL mid_reset_bus_drive got %b expected 0", bus_drive); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy got %b expected 0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL mid_reset_done got %b expected 0", done); end
        n_tests++; if (last_value !== 8'h00) begin n_fail++; $display("FAIL mid_reset_last_value got %h expected 00", last_value); end
        Tick = 1'b0;
        #1 Reset = 1'b0;
        model_reset();
        step();
        n_tests++; if (obs_vec !== exp_vec()) begin n_fail++; $display("FAIL mid_reset_after got %h expected %h", obs_vec, exp_vec()); end
    endtask

    task automatic test_random();
        int  ticks;
        int  cyc;
        logic t;
        ticks = 0; cyc = 0;
        while (ticks < 1000 && cyc < 5000) begin
            t = 1'($urandom_range(1, 0));
            Tick = t; req = 1'($urandom_range(1, 0)); imm_en = 1'($urandom_range(1, 0));
            src_sel = AB'($urandom); dst_sel = AB'($urandom); imm_data = NB'($urandom);
            step();
            if (t) ticks++;
            cyc++;
            n_tests++; if ($countones(~cs) > 1) begin n_fail++; $display("FAIL rand_cs_onehot0 cyc%0d got %b expected at most one zero", cyc, cs); end
            n_tests++; if (bus_drive && cs !== 4'hF) begin n_fail++; $display("FAIL rand_cs_vs_drive cyc%0d got cs=%b expected 1111", cyc, cs); end
            n_tests++; if ($countones(load_en) > 1) begin n_fail++; $display("FAIL rand_load_onehot0 cyc%0d got %b expected zero or one-hot", cyc, load_en); end
            n_tests++; if (obs_vec !== exp_vec()) begin n_fail++; $display("FAIL rand_model cyc%0d got %h expected %h", cyc, obs_vec, exp_vec()); end
        end
        n_tests++; if (ticks < 1000) begin n_fail++; $display("FAIL rand_tick_budget got %0d expected 1000", ticks); end
        for (int i = 0; i < NR; i++) begin
            n_tests++; if (bank[i] !== mregs[i]) begin n_fail++; $display("FAIL rand_bank%0d got %h expected %h", i, bank[i], mregs[i]); end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_imm();
        test_reg_move();
        test_slow_tick();
        test_ignore_busy();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
